// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch controller.
//   fetch_state_e  - two-state fetch FSM encoding (REQ / WAIT)
//   NOP_INST       - instruction value used when no real instruction exists
//   RST_*          - reset values of controller state and the decode-facing register
//   pc_misaligned  - word-alignment test on the two low PC bits
package fetch_pkg;

   typedef enum logic {
      ST_REQ  = 1'b0,
      ST_WAIT = 1'b1
   } fetch_state_e;

   localparam logic [31:0]  NOP_INST    = 32'h0000_0000;
   localparam fetch_state_e RST_STATE   = ST_REQ;
   localparam logic         RST_DISCARD = 1'b0;
   localparam logic         RST_VALID   = 1'b0;
   localparam logic         RST_ADEL    = 1'b0;
   localparam logic [31:0]  RST_PC      = 32'h0000_0000;

   function automatic logic pc_misaligned(input logic [1:0] pc_lo);
      return (pc_lo != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding buffer for a fetched instruction that
// arrived while the decode-facing register was occupied and stalled.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   i_clr             - flush (redirect); highest priority
//   i_push            - load {i_data, i_pc, i_adel}; wins over i_pop
//   i_pop             - entry moved to the output register
//   o_full            - entry present
//   o_data/o_pc/o_adel- stored entry
module fetch_skid_buf
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   input  logic [WIDTH-1:0] i_pc,
   input  logic             i_adel,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data,
   output logic [WIDTH-1:0] o_pc,
   output logic             o_adel
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_pc;
   logic             r_adel;

   // Entry storage; a push in the same cycle as a pop keeps the buffer full with the new entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
         r_data <= WIDTH'(NOP_INST);
         r_pc   <= WIDTH'(RST_PC);
         r_adel <= RST_ADEL;
      end else if (i_clr) begin
         r_full <= 1'b0;
      end else if (i_push) begin
         r_full <= 1'b1;
         r_data <= i_data;
         r_pc   <= i_pc;
         r_adel <= i_adel;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;
   assign o_pc   = r_pc;
   assign o_adel = r_adel;

endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch controller between the PC register, an
// SRAM-like instruction bus (one outstanding request) and the decode stage.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-PC fetch exception).
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   pc_q                         - current PC
//   pc_en, pc_clr, pc_t          - PC advance / redirect load / redirect target
//   redirect_valid, redirect_pc  - branch/exception redirect
//   id_stall                     - decode not accepting
//   inst_req, inst_addr          - bus request and address
//   inst_addr_ok, inst_data_ok   - bus address / data handshakes
//   inst_rdata                   - returned instruction
//   if_valid, if_inst, if_pc,    - registered decode-facing outputs
//   if_adel                        (if_adel is constant 0 without the macro)
module if_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc_q,
   output logic             pc_en,
   output logic             pc_clr,
   output logic [WIDTH-1:0] pc_t,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             id_stall,
   output logic             inst_req,
   output logic [WIDTH-1:0] inst_addr,
   input  logic             inst_addr_ok,
   input  logic             inst_data_ok,
   input  logic [WIDTH-1:0] inst_rdata,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_inst,
   output logic [WIDTH-1:0] if_pc,
   output logic             if_adel
);

   fetch_state_e     r_state;
   logic             r_discard;
   logic [WIDTH-1:0] r_req_pc;
   logic             r_if_valid;
   logic [WIDTH-1:0] r_if_inst;
   logic [WIDTH-1:0] r_if_pc;
   logic             r_if_adel;

   logic             w_skid_full;
   logic [WIDTH-1:0] w_skid_data;
   logic [WIDTH-1:0] w_skid_pc;
   logic             w_skid_adel;
   logic             w_misalign;
   logic             w_adel_new;
   logic             w_req;
   logic             w_accept;
   logic             w_data_take;
   logic             w_new_vld;
   logic [WIDTH-1:0] w_new_data;
   logic [WIDTH-1:0] w_new_pc;
   logic             w_out_free;
   logic             w_skid_push;
   logic             w_skid_pop;

`ifdef FETCH_ALIGN_CHECK_EN
   logic r_adel_sent;

   assign w_misalign = pc_misaligned(pc_q[1:0]);
   // The exception entry is produced once per misaligned PC; only a redirect or reset re-arms it.
   assign w_adel_new = (r_state == ST_REQ) && w_misalign && !r_adel_sent &&
                       !redirect_valid && !w_skid_full;

   // Tracks whether the address-error entry for the current PC was already delivered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_adel_sent <= 1'b0;
      end else if (redirect_valid) begin
         r_adel_sent <= 1'b0;
      end else if (w_adel_new) begin
         r_adel_sent <= 1'b1;
      end
   end
`else
   assign w_misalign = 1'b0;
   assign w_adel_new = 1'b0;
`endif

   // A new request is only possible with the skid empty, so a returning fetch always has a slot.
   assign w_req     = !rst && (r_state == ST_REQ) && !redirect_valid && !w_skid_full && !w_misalign;
   assign w_accept  = w_req && inst_addr_ok;
   assign inst_req  = w_req;
   assign inst_addr = pc_q;
   assign pc_en     = w_accept;
   assign pc_clr    = !rst && redirect_valid;
   assign pc_t      = redirect_pc;

   // Data in the redirect cycle belongs to the abandoned path and is dropped.
   assign w_data_take = (r_state == ST_WAIT) && inst_data_ok && !r_discard && !redirect_valid;
   assign w_new_vld   = w_data_take || w_adel_new;
   assign w_new_data  = w_adel_new ? WIDTH'(NOP_INST) : inst_rdata;
   assign w_new_pc    = w_adel_new ? pc_q : r_req_pc;

   assign w_out_free  = !r_if_valid || !id_stall;
   assign w_skid_pop  = w_out_free && w_skid_full;
   // New entry goes straight to the output register unless it is held or the skid is older.
   assign w_skid_push = w_new_vld && !(w_out_free && !w_skid_full);

   fetch_skid_buf #(.WIDTH(WIDTH)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (redirect_valid),
      .i_push (w_skid_push),
      .i_pop  (w_skid_pop),
      .i_data (w_new_data),
      .i_pc   (w_new_pc),
      .i_adel (w_adel_new),
      .o_full (w_skid_full),
      .o_data (w_skid_data),
      .o_pc   (w_skid_pc),
      .o_adel (w_skid_adel)
   );

   // Fetch FSM: one outstanding request; discard marks a response owed to a redirected path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= RST_STATE;
         r_discard <= RST_DISCARD;
         r_req_pc  <= WIDTH'(RST_PC);
      end else begin
         case (r_state)
            ST_REQ: begin
               if (w_accept) begin
                  r_state  <= ST_WAIT;
                  r_req_pc <= pc_q;
               end else begin
                  r_state  <= ST_REQ;
               end
            end
            ST_WAIT: begin
               if (inst_data_ok) begin
                  r_state   <= ST_REQ;
                  r_discard <= 1'b0;
               end else if (redirect_valid) begin
                  r_discard <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_REQ;
               r_discard <= 1'b0;
            end
         endcase
      end
   end

   // Decode-facing register: skid entry has priority over fresh data to keep program order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_if_valid <= RST_VALID;
         r_if_inst  <= WIDTH'(NOP_INST);
         r_if_pc    <= WIDTH'(RST_PC);
         r_if_adel  <= RST_ADEL;
      end else if (redirect_valid) begin
         r_if_valid <= 1'b0;
      end else if (w_out_free) begin
         if (w_skid_full) begin
            r_if_valid <= 1'b1;
            r_if_inst  <= w_skid_data;
            r_if_pc    <= w_skid_pc;
            r_if_adel  <= w_skid_adel;
         end else if (w_new_vld) begin
            r_if_valid <= 1'b1;
            r_if_inst  <= w_new_data;
            r_if_pc    <= w_new_pc;
            r_if_adel  <= w_adel_new;
         end else begin
            r_if_valid <= 1'b0;
         end
      end
   end

   assign if_valid = r_if_valid;
   assign if_inst  = r_if_inst;
   assign if_pc    = r_if_pc;
   assign if_adel  = r_if_adel;

endmodule
